systolic_seq: RTL and testbench

Sequencer that sits directly upstream of the 8-PE systolic array and drives all of its control and operand inputs. It accepts a single nibble stream over a valid/ready handshake: weights, then biases, then samples. It loads each PE, streams the samples down the data chain with per-PE accumulate enables aligned to the chain skew, then drains all accumulators through the array's `drain_sel` mux. Drained results leave on a valid/ready output.

---
 rtl/systolic_seq_pkg.sv | 17 +
 rtl/systolic_seq_skew_line.sv | 17 +
 rtl/systolic_seq.sv | 126 ++++++++++++
 tb/tb_systolic_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_seq_pkg.sv
// Shared types for the systolic array sequencer: state encoding and PE index width.
package systolic_pkg;

  localparam int NUM_PE_DEF = 8;

  typedef logic [$clog2(NUM_PE_DEF)-1:0] pe_idx_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_B = 3'd2,
    STREAM = 3'd3,
    FLUSH  = 3'd4,
    DRAIN  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/systolic_seq_skew_line.sv
// Valid shift register producing per-PE accumulate enables, one cycle of skew per PE.
module seq_skew_line #(
  parameter int NUM_PE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              feed,
  output logic [NUM_PE-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else            q <= (q << 1) | NUM_PE'(feed);
  end

endmodule

// File: rtl/systolic_seq.sv
// Sequencer for the 8-PE systolic array: loads weights/biases, streams samples, drains results.
// Optional bias load phase is enabled by defining SYSTOLIC_SEQ_BIAS_EN.
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_DEF,
  parameter int DW     = 4,
  parameter int AW     = 8,
  parameter int LEN_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW-1:0]             in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [AW-1:0]             out_data,
  output logic [$clog2(NUM_PE)-1:0] out_idx,
  output logic                      busy,
  output logic                      done,
  output logic [DW-1:0]             weight_out,
  output logic [DW-1:0]             bias_out,
  output logic [DW-1:0]             data_out,
  output logic [NUM_PE-1:0]         pe_weight_en,
  output logic [NUM_PE-1:0]         pe_bias_en,
  output logic [NUM_PE-1:0]         pe_acc_en,
  output logic [$clog2(NUM_PE)-1:0] drain_sel,
  input  logic [AW-1:0]             acc_in
);

  localparam int IW = $clog2(NUM_PE);
  localparam logic [IW-1:0] LAST = IW'(NUM_PE - 1);

  seq_state_t        state, next;
  logic [IW-1:0]     idx;
  logic [LEN_W-1:0]  len_q, cnt;
  logic              accept, idx_last, in_drain;
  logic [NUM_PE-1:0] sel_onehot;

  assign in_ready   = (state == LOAD_W) || (state == LOAD_B) || (state == STREAM);
  assign accept     = in_valid && in_ready;
  assign busy       = (state != IDLE);
  assign idx_last   = (idx == LAST);
  assign sel_onehot = NUM_PE'(1) << idx;

  assign in_drain  = (state == DRAIN);
  assign out_valid = in_drain;
  assign out_data  = in_drain ? acc_in : '0;
  assign out_idx   = in_drain ? idx : '0;
  assign drain_sel = out_idx;

  always_comb begin
    next = state;
    case (state)
      IDLE:   if (start) next = LOAD_W;
`ifdef SYSTOLIC_SEQ_BIAS_EN
      LOAD_W: if (accept && idx_last) next = LOAD_B;
      LOAD_B: if (accept && idx_last) next = (len_q == '0) ? DRAIN : STREAM;
`else
      LOAD_W: if (accept && idx_last) next = (len_q == '0) ? DRAIN : STREAM;
`endif
      STREAM: if (accept && (cnt == len_q - 1'b1)) next = FLUSH;
      FLUSH:  if (idx_last) next = DRAIN;
      DRAIN:  if (out_ready && idx_last) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // idx doubles as the FLUSH cycle counter; it is cleared on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      len_q        <= '0;
      done         <= 1'b0;
      weight_out   <= '0;
      pe_weight_en <= '0;
      data_out     <= '0;
    end else begin
      state <= next;
      done  <= in_drain && (next == IDLE);
      if (state == IDLE && start) len_q <= len;

      if (next != state)
        idx <= '0;
      else if (((state == LOAD_W || state == LOAD_B) && accept) ||
               (state == FLUSH) || (in_drain && out_ready))
        idx <= idx + 1'b1;

      if (next != state)                  cnt <= '0;
      else if (state == STREAM && accept) cnt <= cnt + 1'b1;

      weight_out   <= (state == LOAD_W && accept) ? in_data : '0;
      pe_weight_en <= (state == LOAD_W && accept) ? sel_onehot : '0;
      data_out     <= (state == STREAM && accept) ? in_data : '0;
    end
  end

`ifdef SYSTOLIC_SEQ_BIAS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bias_out   <= '0;
      pe_bias_en <= '0;
    end else begin
      bias_out   <= (state == LOAD_B && accept) ? in_data : '0;
      pe_bias_en <= (state == LOAD_B && accept) ? sel_onehot : '0;
    end
  end
`else
  assign bias_out   = '0;
  assign pe_bias_en = '0;
`endif

  seq_skew_line #(.NUM_PE(NUM_PE)) u_skew (
    .clk  (clk),
    .rst  (rst),
    .clr  (!(state == STREAM || state == FLUSH)),
    .feed (state == STREAM && accept),
    .q    (pe_acc_en)
  );

endmodule

// File: tb/tb_systolic_seq.sv
// Scoreboard bench for systolic_seq: driver pushes expectations, negedge monitor compares.
module tb_systolic_seq;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] len = '0;
  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0] in_data = '0;
  logic       in_ready, out_valid, busy, done;
  logic [7:0] out_data, acc_in;
  logic [2:0] out_idx, drain_sel;
  logic [3:0] weight_out, bias_out, data_out;
  logic [7:0] pe_weight_en, pe_bias_en, pe_acc_en;

  systolic_seq #(.NUM_PE(8), .DW(4), .AW(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done),
    .weight_out(weight_out), .bias_out(bias_out), .data_out(data_out),
    .pe_weight_en(pe_weight_en), .pe_bias_en(pe_bias_en), .pe_acc_en(pe_acc_en),
    .drain_sel(drain_sel), .acc_in(acc_in)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int k; logic [3:0] d; } pulse_t;

  int         errors = 0, checks = 0;
  int         cyc = 0, last_rst = 0, drain_start = 32'h7fffffff, done_cyc = -1;
  bit         mon_en = 1'b0;
  pulse_t     wq[$], bq[$];
  int         drain_q[$];
  logic [3:0] samp_at[int];
  logic [3:0] w_arr[8], b_arr[8], s_arr[2];
  logic [7:0] model_acc[8];

  // Behavioural stand-in for the array's accumulator output mux.
  assign acc_in = model_acc[drain_sel];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) if (mon_en) begin
    pulse_t     p;
    logic [7:0] e;
    bit         in_dr;
    int         id;
    if (wq.size() > 0 && wq[0].cyc == cyc) begin
      p = wq.pop_front();
      chk("weight_en", pe_weight_en, 32'(8'(1) << p.k));
      chk("weight_out", weight_out, p.d);
    end else chk("weight_en_idle", pe_weight_en, 0);
    if (bq.size() > 0 && bq[0].cyc == cyc) begin
      p = bq.pop_front();
      chk("bias_en", pe_bias_en, 32'(8'(1) << p.k));
      chk("bias_out", bias_out, p.d);
    end else chk("bias_en_idle", pe_bias_en, 0);
    e = '0;
    for (int i = 0; i < 8; i++)
      if (samp_at.exists(cyc - i) && (cyc - i) >= last_rst) e[i] = 1'b1;
    chk("acc_en", pe_acc_en, e);
    chk("data_out", data_out, samp_at.exists(cyc) ? samp_at[cyc] : 4'd0);
    in_dr = (drain_q.size() > 0) && (cyc >= drain_start);
    chk("out_valid", out_valid, in_dr);
    if (in_dr) begin
      id = drain_q[0];
      chk("out_idx", out_idx, id);
      chk("drain_sel", drain_sel, id);
      chk("out_data", out_data, model_acc[id]);
      chk("busy_drain", busy, 1);
      if (out_ready) begin
        void'(drain_q.pop_front());
        if (drain_q.size() == 0) done_cyc = cyc + 1;
      end
    end
    chk("done", done, cyc == done_cyc);
    if (cyc == done_cyc) chk("busy_at_done", busy, 0);
  end

  // Present one beat; acceptance is expected at the next edge since in_ready is high.
  task automatic put(input bit v, input logic [3:0] d, output int a);
    in_valid = v;
    in_data  = d;
    chk("in_ready", in_ready, 1);
    @(posedge clk); #1;
    a = cyc;
    in_valid = 1'b0;
  endtask

  task automatic run_job(input int n, input int mode, input bit stall, input int abort_after);
    int a, last_a, got, tries, stall_cnt;
    bit v;
    logic [3:0] d;
    logic [3:0] pat[4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    for (int k = 0; k < 8; k++) model_acc[k] = 8'($urandom);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    len   = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len   = 8'($urandom);
    last_a = 0;
    for (int k = 0; k < 8; k++) begin
      put(1'b1, w_arr[k], a);
      wq.push_back('{a, k, w_arr[k]});
      last_a = a;
    end
`ifdef SYSTOLIC_SEQ_BIAS_EN
    for (int k = 0; k < 8; k++) begin
      put(1'b1, b_arr[k], a);
      bq.push_back('{a, k, b_arr[k]});
      last_a = a;
    end
`endif
    got = 0;
    tries = 0;
    while (got < n && tries < 2000) begin
      if (abort_after > 0 && got == abort_after) break;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? pat[tries % 4][0] : ($urandom_range(0, 2) != 0);
      d = (mode == 0 && got < 2) ? s_arr[got] : 4'($urandom);
      tries++;
      put(v, d, a);
      if (v) begin
        samp_at[a] = d;
        got++;
        last_a = a;
      end
    end
    if (abort_after > 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      last_rst = cyc;
      wq.delete();
      bq.delete();
      chk("abort_in_ready", in_ready, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      repeat (3) @(posedge clk);
      #1;
      return;
    end
    drain_start = (n == 0) ? last_a : last_a + 8;
    for (int k = 0; k < 8; k++) drain_q.push_back(k);
    stall_cnt = 0;
    for (int t = 0; t < 400; t++) begin
      if (drain_q.size() == 0 && cyc > done_cyc) break;
      out_ready = !(stall && cyc >= drain_start && drain_q.size() == 5 && stall_cnt < 5);
      if (!out_ready) stall_cnt++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("drain_finished", drain_q.size(), 0);
    drain_q.delete();
    drain_start = 32'h7fffffff;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    last_rst = cyc;
    chk("rst_weight_en", pe_weight_en, 0);
    chk("rst_bias_en", pe_bias_en, 0);
    chk("rst_acc_en", pe_acc_en, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_weight_out", weight_out, 0);
    chk("rst_bias_out", bias_out, 0);
    chk("rst_drain_sel", drain_sel, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    mon_en = 1'b1;

    for (int k = 0; k < 8; k++) begin
      w_arr[k] = 4'(k + 1);
      b_arr[k] = 4'd0;
    end
    s_arr[0] = 4'd2;
    s_arr[1] = 4'd3;
    run_job(2, 0, 1'b0, 0);

    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < 8; k++) begin
        w_arr[k] = 4'($urandom);
        b_arr[k] = 4'($urandom);
      end
      case (j)
        0: run_job(8, 1, 1'b1, 0);
        1: run_job(0, 0, 1'b0, 0);
        2: run_job(12, 2, 1'b0, 4);
        3: run_job($urandom_range(1, 20), 2, 1'b0, 0);
        4: run_job($urandom_range(1, 20), 2, 1'b1, 0);
        default: run_job(1, 0, 1'b0, 0);
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
